// File: rtl/activation_pipe.sv
// rtl/activation_pipe.sv - multi-lane FP32 sigmoid/tanh/ReLU/identity activation stage
// Three register stages (unpack, piecewise-linear, repack) sharing one advance enable.
module activation_pipe #(
  parameter int LANES     = 1,
  parameter int FRAC_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mode,
  input  logic [32*LANES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*LANES-1:0] out_data
);
  localparam int ZW = FRAC_BITS + 4;
  localparam int YW = FRAC_BITS + 1;

  localparam logic [1:0] MODE_SIGMOID = 2'b00;
  localparam logic [1:0] MODE_TANH    = 2'b01;
  localparam logic [1:0] MODE_RELU    = 2'b10;
  localparam logic [1:0] MODE_IDENT   = 2'b11;

  localparam logic [31:0] FP_QNAN      = 32'h7FC0_0000;
  localparam logic [31:0] FP_ONE       = 32'h3F80_0000;
  localparam logic [31:0] FP_MINUS_ONE = 32'hBF80_0000;

  localparam logic [ZW-1:0] Z_ONE  = ZW'(1 << FRAC_BITS);
  localparam logic [ZW-1:0] Z_KNEE = ZW'(19 << (FRAC_BITS - 3));
  localparam logic [ZW-1:0] Z_FIVE = ZW'(5 << FRAC_BITS);
  localparam logic [YW-1:0] Y_ONE  = YW'(1 << FRAC_BITS);
  localparam logic [YW-1:0] Y_HIGH = YW'(27 << (FRAC_BITS - 5));
  localparam logic [YW-1:0] Y_MID  = YW'(5 << (FRAC_BITS - 3));
  localparam logic [YW-1:0] Y_LOW  = YW'(1 << (FRAC_BITS - 1));

  // Magnitude is always below 16 here, so the significand only ever shifts right.
  function automatic logic [ZW-1:0] abs_to_fixed(input logic [7:0] e, input logic [22:0] m);
    int          rsh;
    logic [23:0] sig;
    sig = {1'b1, m};
    rsh = 150 - FRAC_BITS - int'(e);
    if (e == 8'd0) return '0;
    if (e >= 8'd131) return '1;
    if (rsh >= 24) return '0;
    return ZW'(sig >> rsh);
  endfunction

  // Tanh uses modular 2y-1: the true result never exceeds 1.0, so wrap-around is harmless.
  function automatic logic [YW-1:0] plan(input logic [ZW-1:0] z, input logic [1:0] mode,
                                         input logic sign);
    logic [YW-1:0] y;
    if (z >= Z_FIVE)      y = Y_ONE;
    else if (z >= Z_KNEE) y = YW'(z >> 5) + Y_HIGH;
    else if (z >= Z_ONE)  y = YW'(z >> 3) + Y_MID;
    else                  y = YW'(z >> 2) + Y_LOW;
    if (mode == MODE_TANH) return (y << 1) - Y_ONE;
    if (mode == MODE_SIGMOID && sign) return Y_ONE - y;
    return y;
  endfunction

  function automatic logic [31:0] fixed_to_fp(input logic [YW-1:0] y);
    int          p;
    logic [22:0] mant;
    p = 0;
    for (int b = 0; b < YW; b++) if (y[b]) p = b;
    mant = 23'(y) << (23 - p);
    if (y == '0) return 32'h0;
    return {1'b0, 8'(127 + p - FRAC_BITS), mant};
  endfunction

  logic                     adv;
  logic                     v1, v2;
  logic [1:0]               mode1, mode2;
  logic [LANES-1:0][ZW-1:0] z_next, z1;
  logic [LANES-1:0][YW-1:0] y_next, y2;
  logic [LANES-1:0][31:0]   raw1, raw2;
  logic [LANES-1:0]         nan_next, inf_next, nan1, inf1, nan2, inf2;
  logic [32*LANES-1:0]      out_next;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [30:0]   x;
    logic [ZW-1:0] mag;
    logic [31:0]   fp;
    logic [31:0]   r;

    assign x           = in_data[32*i +: 31];
    assign mag         = abs_to_fixed(x[30:23], x[22:0]);
    assign nan_next[i] = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    assign inf_next[i] = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    assign z_next[i]   = (in_mode != MODE_TANH) ? mag :
                         mag[ZW-1] ? '1 : {mag[ZW-2:0], 1'b0};

    assign y_next[i] = plan(z1[i], mode1, raw1[i][31]);

    assign fp = fixed_to_fp(y2[i]);
    always_comb begin
      r = fp;
      case (mode2)
        MODE_IDENT: r = raw2[i];
        MODE_RELU: begin
          if (nan2[i])          r = FP_QNAN;
          else if (raw2[i][31]) r = 32'h0;
          else                  r = raw2[i];
        end
        MODE_SIGMOID: begin
          if (nan2[i])      r = FP_QNAN;
          else if (inf2[i]) r = raw2[i][31] ? 32'h0 : FP_ONE;
        end
        default: begin
          if (nan2[i])          r = FP_QNAN;
          else if (inf2[i])     r = raw2[i][31] ? FP_MINUS_ONE : FP_ONE;
          else if (fp != 32'h0) r = {raw2[i][31], fp[30:0]};
        end
      endcase
    end
    assign out_next[32*i +: 32] = r;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      out_data  <= out_next;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      mode1 <= in_mode;
      z1    <= z_next;
      raw1  <= in_data;
      nan1  <= nan_next;
      inf1  <= inf_next;
      mode2 <= mode1;
      y2    <= y_next;
      raw2  <= raw1;
      nan2  <= nan1;
      inf2  <= inf1;
    end
  end
endmodule
